stopwatch_ctrl: RTL and testbench

Controller that sequences the two-digit BCD count datapath as a push-button stopwatch on the DE1 board. Debounces two raw buttons, runs a START/PAUSE/LAP/CLEAR state machine, generates the count tick from CLOCK_50 and owns the 00..99 BCD count. Provides a frozen-lap display path. Output digits feed the existing 7-segment BCD decoders directly.

---
 rtl/stopwatch_if.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
// Stopwatch button inputs and display/status outputs.
// The controller drives through master; a board or bench uses slave.
interface stopwatch_if;
  logic       start_n;
  logic       lap_n;
  logic [3:0] disp_ones;
  logic [3:0] disp_tens;
  logic       running;
  logic       lap_active;
  logic       tick;
  logic       rollover;

  modport master (
    input  start_n,
    input  lap_n,
    output disp_ones,
    output disp_tens,
    output running,
    output lap_active,
    output tick,
    output rollover
  );

  modport slave (
    output start_n,
    output lap_n,
    input  disp_ones,
    input  disp_tens,
    input  running,
    input  lap_active,
    input  tick,
    input  rollover
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Push-button stopwatch: debounce, START/PAUSE/LAP/CLEAR FSM,
// tick prescaler and two-digit BCD count with a frozen lap view.
module stopwatch_ctrl #(
  parameter int CLK_HZ       = 50000000,
  parameter int TICK_HZ      = 1,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic        CLOCK_50,
  input  logic        KEY,
  stopwatch_if.master sw
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LAP   = 2'd2;
  localparam logic [1:0] S_PAUSE = 2'd3;

  // bit 0 = START/PAUSE, bit 1 = LAP/CLEAR
  logic [1:0]         raw;
  logic [1:0]         s1;
  logic [1:0]         s2;
  logic [1:0]         db;
  logic [1:0]         dbq;
  logic [1:0]         press;
  logic [1:0][DW-1:0] cnt;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic [3:0]    lap_ones;
  logic [3:0]    lap_tens;

  logic start_ev;
  logic lap_ev;
  logic active;
  logic wrap;

  assign raw = {sw.lap_n, sw.start_n};

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      s1    <= '1;
      s2    <= '1;
      db    <= '1;
      dbq   <= '1;
      press <= '0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      dbq   <= db;
      press <= dbq & ~db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == D_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DW'(1);
        end
      end
    end
  end

  // START has priority when both events land together
  assign start_ev = press[0];
  assign lap_ev   = press[1] & ~press[0];

  assign active = (state == S_RUN) || (state == S_LAP);
  assign wrap   = active && (presc == P_LAST);

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state    <= S_IDLE;
      presc    <= '0;
      ones     <= '0;
      tens     <= '0;
      lap_ones <= '0;
      lap_tens <= '0;
    end else begin
      if (wrap) begin
        presc <= '0;
        if (ones == 4'd9) begin
          ones <= '0;
          tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end else if (active) begin
        presc <= presc + PW'(1);
      end

      unique case (state)
        S_IDLE: begin
          if (start_ev) begin
            state <= S_RUN;
            presc <= '0;
          end
        end
        S_RUN: begin
          if (start_ev) begin
            state <= S_PAUSE;
          end else if (lap_ev) begin
            state    <= S_LAP;
            lap_ones <= ones;
            lap_tens <= tens;
          end
        end
        S_LAP: begin
          if (start_ev) state <= S_PAUSE;
          else if (lap_ev) state <= S_RUN;
        end
        S_PAUSE: begin
          // resume keeps the prescaler phase
          if (start_ev) begin
            state <= S_RUN;
          end else if (lap_ev) begin
            state    <= S_IDLE;
            presc    <= '0;
            ones     <= '0;
            tens     <= '0;
            lap_ones <= '0;
            lap_tens <= '0;
          end
        end
      endcase
    end
  end

  assign sw.disp_ones  = (state == S_LAP) ? lap_ones : ones;
  assign sw.disp_tens  = (state == S_LAP) ? lap_tens : tens;
  assign sw.running    = active;
  assign sw.lap_active = (state == S_LAP);
  assign sw.tick       = wrap;
  assign sw.rollover   = wrap && (ones == 4'd9) && (tens == 4'd9);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at DIV=20, DEBOUNCE_CYC=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic key = 1'b0;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int tick_cnt = 0;
  int roll_cnt = 0;
  int run_tog  = 0;
  logic run_q  = 1'b0;

  stopwatch_if sw();

  stopwatch_ctrl #(
    .CLK_HZ      (20),
    .TICK_HZ     (1),
    .DEBOUNCE_CYC(4)
  ) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .sw      (sw)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sw.tick) tick_cnt++;
    if (sw.rollover) roll_cnt++;
    if (sw.running !== run_q) run_tog++;
    run_q = sw.running;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sw.tick && n < 100);
  endtask

  function automatic int disp();
    return int'({sw.disp_tens, sw.disp_ones});
  endfunction

  function automatic int outs();
    return int'({sw.disp_tens, sw.disp_ones, sw.running,
                 sw.lap_active, sw.tick, sw.rollover});
  endfunction

  int n;
  int bad;
  int t0;
  int r0;

  initial begin
    sw.start_n = 1'b1;
    sw.lap_n   = 1'b1;

    // 1: reset and idle
    cyc(3);
    chk("reset_outs", outs(), 0);
    key = 1'b1;
    cyc(100);
    chk("idle_ticks", tick_cnt, 0);
    chk("idle_rolls", roll_cnt, 0);
    chk("idle_run", int'(sw.running), 0);
    chk("idle_disp", disp(), 'h00);

    // 2: start, latency and tick rate
    sw.start_n = 1'b0;
    cyc(7);
    chk("start_lat_lo", int'(sw.running), 0);
    cyc(1);
    chk("start_lat_hi", int'(sw.running), 1);
    cyc(2);
    sw.start_n = 1'b1;
    wait_tick(n);
    chk("first_tick", n, 17);
    bad = 0;
    for (int i = 0; i < 11; i++) begin
      wait_tick(n);
      if (n != 20) bad++;
    end
    chk("tick_period", bad, 0);
    cyc(1);
    chk("disp_12", disp(), 'h12);

    // 3: bouncing start, one event, pause lands on a tick
    r0 = run_tog;
    for (int p = 0; p < 6; p++) begin
      sw.start_n = p[0];
      cyc(2);
    end
    sw.start_n = 1'b0;
    cyc(7);
    chk("bounce_run", int'(sw.running), 1);
    chk("pause_tick", int'(sw.tick), 1);
    cyc(1);
    chk("bounce_pause", int'(sw.running), 0);
    chk("pause_inc", disp(), 'h13);
    cyc(20);
    sw.start_n = 1'b1;
    chk("bounce_toggles", run_tog - r0, 1);
    chk("pause_hold", disp(), 'h13);
    cyc(10);

    // clear from pause, then run up to 05
    sw.lap_n = 1'b0;
    cyc(8);
    chk("clear_run", int'(sw.running), 0);
    chk("clear_disp", disp(), 'h00);
    sw.lap_n = 1'b1;
    cyc(10);
    sw.start_n = 1'b0;
    cyc(8);
    chk("restart_run", int'(sw.running), 1);
    cyc(2);
    sw.start_n = 1'b1;
    wait_tick(n);
    chk("restart_tick", n, 17);
    repeat (4) wait_tick(n);
    cyc(1);
    chk("disp_05", disp(), 'h05);

    // 4: lap freeze while live count advances
    sw.lap_n = 1'b0;
    cyc(7);
    chk("lap_lat_lo", int'(sw.lap_active), 0);
    cyc(1);
    chk("lap_active", int'(sw.lap_active), 1);
    chk("lap_disp", disp(), 'h05);
    cyc(2);
    sw.lap_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      cyc(1);
      if (disp() != 'h05 || !sw.lap_active) bad++;
    end
    chk("lap_frozen", bad, 0);
    sw.lap_n = 1'b0;
    cyc(7);
    chk("lap_exit_lo", disp(), 'h05);
    cyc(1);
    chk("lap_exit_act", int'(sw.lap_active), 0);
    chk("lap_exit_disp", disp(), 'h08);
    cyc(2);
    sw.lap_n = 1'b1;

    // 5: 98 -> 99 -> 00 with rollover
    repeat (90) wait_tick(n);
    cyc(1);
    chk("disp_98", disp(), 'h98);
    wait_tick(n);
    chk("roll_early", int'(sw.rollover), 0);
    cyc(1);
    chk("disp_99", disp(), 'h99);
    wait_tick(n);
    chk("roll_tick", int'(sw.rollover), 1);
    cyc(1);
    chk("roll_drop", int'(sw.rollover), 0);
    chk("disp_00", disp(), 'h00);
    chk("roll_count", roll_cnt, 1);

    // 6: pause at prescaler 11, phase kept on resume
    repeat (37) wait_tick(n);
    cyc(1);
    chk("disp_37", disp(), 'h37);
    cyc(3);
    sw.start_n = 1'b0;
    cyc(7);
    chk("p37_run", int'(sw.running), 1);
    cyc(1);
    chk("p37_pause", int'(sw.running), 0);
    cyc(2);
    sw.start_n = 1'b1;
    t0 = tick_cnt;
    cyc(60);
    chk("pause_no_tick", tick_cnt - t0, 0);
    chk("pause_disp", disp(), 'h37);
    sw.start_n = 1'b0;
    cyc(7);
    chk("resume_lo", int'(sw.running), 0);
    cyc(1);
    chk("resume_hi", int'(sw.running), 1);
    wait_tick(n);
    chk("resume_phase", n, 8);
    sw.start_n = 1'b1;
    cyc(1);
    chk("disp_38", disp(), 'h38);
    cyc(10);
    sw.start_n = 1'b0;
    cyc(8);
    chk("pause2", int'(sw.running), 0);
    cyc(2);
    sw.start_n = 1'b1;
    cyc(10);
    sw.lap_n = 1'b0;
    cyc(8);
    chk("idle2_disp", disp(), 'h00);
    chk("idle2_run", int'(sw.running), 0);
    cyc(2);
    sw.lap_n = 1'b1;
    cyc(10);
    sw.start_n = 1'b0;
    cyc(8);
    chk("run3", int'(sw.running), 1);
    sw.start_n = 1'b1;
    wait_tick(n);
    chk("idle_presc_clr", n, 19);
    cyc(25);
    chk("pre_rst_run", int'(sw.running), 1);

    // asynchronous reset mid-run, START held through it
    key = 1'b0;
    #1;
    chk("async_rst", outs(), 0);
    sw.start_n = 1'b0;
    cyc(2);
    key = 1'b1;
    cyc(7);
    chk("held_lo", int'(sw.running), 0);
    cyc(1);
    chk("held_hi", int'(sw.running), 1);
    sw.start_n = 1'b1;
    cyc(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
